// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames recovered from an oversampled async line by mid-bit sampling,
// delivered through a single-entry output register with a valid/ack handshake.
module uart_rx #(
  parameter int BAUD     = 9600,
  parameter int CLK_FREQ = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ack,
  output logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CLK_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT    = CLK_PER_BIT / 2;
  localparam int CNT_W       = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] clk_count, clk_count_next;
  logic [2:0]       bit_count, bit_count_next;
  logic [7:0]       shift, shift_next;
  logic             rx_meta, rx_s;
  logic             load, drop, ferr;
  logic             ack_take;

  // Synchronizer flops reset to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      clk_count <= '0;
      bit_count <= '0;
      shift     <= '0;
    end else begin
      state     <= state_next;
      clk_count <= clk_count_next;
      bit_count <= bit_count_next;
      shift     <= shift_next;
    end
  end

  always_comb begin
    state_next     = state;
    clk_count_next = clk_count;
    bit_count_next = bit_count;
    shift_next     = shift;
    load           = 1'b0;
    drop           = 1'b0;
    ferr           = 1'b0;
    case (state)
      IDLE: begin
        clk_count_next = '0;
        bit_count_next = '0;
        if (!rx_s) state_next = START;
      end
      START: begin
        // A start bit still low at its midpoint is real; otherwise it was a glitch.
        if (clk_count == HALF_LAST) begin
          clk_count_next = '0;
          state_next     = rx_s ? IDLE : DATA;
        end else begin
          clk_count_next = clk_count + 1'b1;
        end
      end
      DATA: begin
        if (clk_count == BIT_LAST) begin
          clk_count_next        = '0;
          shift_next[bit_count] = rx_s;
          if (bit_count == 3'd7) state_next = STOP;
          else                   bit_count_next = bit_count + 3'd1;
        end else begin
          clk_count_next = clk_count + 1'b1;
        end
      end
      STOP: begin
        if (clk_count == BIT_LAST) begin
          clk_count_next = '0;
          if (rx_s) begin
            state_next = IDLE;
            if (!data_valid || data_ack) load = 1'b1;
            else                         drop = 1'b1;
          end else begin
            ferr       = 1'b1;
            state_next = BREAK;
          end
        end else begin
          clk_count_next = clk_count + 1'b1;
        end
      end
      BREAK: begin
        // A line held low must go high before another start bit is considered.
        clk_count_next = '0;
        if (rx_s) state_next = IDLE;
      end
      default: begin
        state_next     = IDLE;
        clk_count_next = '0;
        bit_count_next = '0;
      end
    endcase
  end

  // Handshake: data is valid while data_valid=1; the consumer takes it on any cycle where
  // data_valid && data_ack. rx_ready is the free-buffer indication, the inverse of data_valid.
  assign ack_take = data_valid && data_ack;
  assign rx_ready = !data_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data       <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= ferr;
      if (load) begin
        data       <= shift;
        data_valid <= 1'b1;
      end else if (ack_take) begin
        data_valid <= 1'b0;
      end
      if (drop)          overrun <= 1'b1;
      else if (ack_take) overrun <= 1'b0;
    end
  end

endmodule
